// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
//   seg_t       : active-low segment vector, bit 6 = a ... bit 0 = g
//   digits_t    : eight hex nibbles, element 0 = rightmost digit
//   disp_word_t : one complete display payload (digits, sign, decimal points)
//   hex2seg     : nibble -> active-low seven-segment pattern
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned SEG_W      = 7;

   typedef logic [SEG_W-1:0] seg_t;
   typedef logic [NUM_DIGITS-1:0][NIB_W-1:0] digits_t;

   typedef struct packed {
      digits_t                 digits;
      logic                    sign;
      logic [NUM_DIGITS-1:0]   dp;
   } disp_word_t;

   localparam seg_t SEG_OFF   = 7'h7F;
   localparam seg_t SEG_MINUS = 7'h7E;

   // Active-low patterns: a segment is lit when its bit is 0.
   function automatic seg_t hex2seg(input logic [NIB_W-1:0] nibble);
      seg_t seg;
      case (nibble)
         4'h0:    seg = 7'h01;
         4'h1:    seg = 7'h4F;
         4'h2:    seg = 7'h12;
         4'h3:    seg = 7'h06;
         4'h4:    seg = 7'h4C;
         4'h5:    seg = 7'h24;
         4'h6:    seg = 7'h20;
         4'h7:    seg = 7'h0F;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h04;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h60;
         4'hC:    seg = 7'h31;
         4'hD:    seg = 7'h42;
         4'hE:    seg = 7'h30;
         4'hF:    seg = 7'h38;
         default: seg = SEG_OFF;
      endcase
      return seg;
   endfunction

endpackage : seg7_pkg

// File: rtl/seg7_scan_driver_if.sv
// Display-word load bus from the IO decoder into the scan driver.
//   digit_in : eight hex nibbles, nibble 0 = rightmost digit
//   sign_in  : 1 = show minus on the leftmost digit
//   dp_in    : per-digit decimal point, 1 = lit
//   load     : one-cycle strobe capturing the three fields above
// Modports: master (IO decoder side), slave (scan driver side).
interface seg7_scan_driver_if;
   import seg7_pkg::*;

   digits_t                 digit_in;
   logic                    sign_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    load;

   modport master (output digit_in, output sign_in, output dp_in, output load);
   modport slave  (input  digit_in, input  sign_in, input  dp_in, input  load);

endinterface : seg7_scan_driver_if

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment decoder.
//   nibble : hex digit to display
//   seg_c  : active-low segments, bit 6 = a ... bit 0 = g
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [NIB_W-1:0] nibble,
   output seg_t             seg_c
);

   assign seg_c = hex2seg(nibble);

endmodule : seg7_hex_decode

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver.
// A new display word is staged in a pending register and only becomes
// visible at a scan-frame boundary, so a frame never mixes two words.
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   bus        : load bus (slave) carrying digit_in / sign_in / dp_in / load
//   AN         : digit enables, active-low, one-hot-low or all-high
//   A2G        : segments, active-low, A2G[6]=a ... A2G[0]=g
//   DP         : decimal point, active-low
//   frame_done : one-cycle pulse after the scan index wraps 7->0
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned PRESCALE_BITS = 17,
   parameter int unsigned BLANK_CYCLES  = 16
)
(
   input  logic                  clk,
   input  logic                  reset,
   seg7_scan_driver_if.slave     bus,
   output logic [NUM_DIGITS-1:0] AN,
   output seg_t                  A2G,
   output logic                  DP,
   output logic                  frame_done
);

   localparam logic [PRESCALE_BITS-1:0] PRE_ONE     = PRESCALE_BITS'(1);
   localparam logic [PRESCALE_BITS-1:0] BLANK_LIMIT = PRESCALE_BITS'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]         LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0]         IDX_ONE     = IDX_W'(1);

   logic [PRESCALE_BITS-1:0] pre_q;
   logic [IDX_W-1:0]         idx_q;
   disp_word_t               pend_q;
   disp_word_t               disp_q;
   disp_word_t               bus_word_c;

   logic                     tick_c;
   logic                     boundary_c;
   logic                     blank_c;
   logic [NUM_DIGITS-1:0]    show_c;
   seg_t                     seg_c;

   logic [NUM_DIGITS-1:0]    an_d;
   seg_t                     a2g_d;
   logic                     dp_d;

   assign bus_word_c = '{digits: bus.digit_in, sign: bus.sign_in, dp: bus.dp_in};
   assign tick_c     = &pre_q;
   assign boundary_c = tick_c && (idx_q == LAST_IDX);
   assign blank_c    = (pre_q < BLANK_LIMIT);

   // Prescaler and digit scan index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q <= '0;
         idx_q <= '0;
      end else begin
         pre_q <= pre_q + PRE_ONE;
         if (tick_c) begin
            idx_q <= idx_q + IDX_ONE;
         end
      end
   end

   // Pending/display staging; a load coinciding with the boundary bypasses
   // the pending register so it is shown in the very next frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q     <= '0;
         disp_q     <= '0;
         frame_done <= 1'b0;
      end else begin
         if (bus.load) begin
            pend_q <= bus_word_c;
         end
         if (boundary_c) begin
            disp_q <= bus.load ? bus_word_c : pend_q;
         end
         frame_done <= boundary_c;
      end
   end

   seg7_hex_decode u_hex_decode (
      .nibble (disp_q.digits[idx_q]),
      .seg_c  (seg_c)
   );

`ifdef SEG7_LZB_EN
   logic lzb_seen_c;

   // A digit is shown when it or any more-significant tested nibble is
   // non-zero; with a sign the leftmost digit carries the minus instead.
   always_comb begin
      lzb_seen_c = 1'b0;
      show_c     = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (!((i == int'(NUM_DIGITS - 1)) && disp_q.sign)) begin
            lzb_seen_c = lzb_seen_c | (|disp_q.digits[IDX_W'(i)]);
         end
         show_c[IDX_W'(i)] = lzb_seen_c;
      end
      show_c[LAST_IDX] = show_c[LAST_IDX] | disp_q.sign;
      show_c[0]        = 1'b1;
   end
`else
   assign show_c = '1;
`endif

   // Next output values; only AN is forced off during the anti-ghost window.
   always_comb begin
      an_d = '1;
      if (!blank_c && show_c[idx_q]) begin
         an_d[idx_q] = 1'b0;
      end
      a2g_d = ((idx_q == LAST_IDX) && disp_q.sign) ? SEG_MINUS : seg_c;
      dp_d  = ~disp_q.dp[idx_q];
   end

   // Registered pad outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         AN  <= '1;
         A2G <= SEG_OFF;
         DP  <= 1'b1;
      end else begin
         AN  <= an_d;
         A2G <= a2g_d;
         DP  <= dp_d;
      end
   end

endmodule : seg7_scan_driver

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (PRESCALE_BITS=3, BLANK_CYCLES=1).
// Stimulus pushes the expected content of specific scan frames; a monitor
// captures every frame that starts with frame_done and compares it.
module tb_seg7_scan_driver;

   logic       clk;
   logic       rst_n;
   logic [7:0] an;
   logic [6:0] a2g;
   logic       dp;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   seg7_scan_driver_if bus_if ();

   seg7_scan_driver #(
      .PRESCALE_BITS (3),
      .BLANK_CYCLES  (1)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .bus        (bus_if),
      .AN         (an),
      .A2G        (a2g),
      .DP         (dp),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          frame;
      logic [55:0] segs;   // digit7 .. digit0, 7 bits each
      logic [7:0]  dp_n;   // expected DP pin per digit
      logic [7:0]  lit;    // 1 = digit enabled outside blanking
   } exp_frame_t;

   exp_frame_t exp_q[$];

`ifdef SEG7_LZB_EN
   localparam logic [7:0] LIT_ZERO = 8'h01;
   localparam logic [7:0] LIT_SIGN = 8'h81;
`else
   localparam logic [7:0] LIT_ZERO = 8'hFF;
   localparam logic [7:0] LIT_SIGN = 8'hFF;
`endif

   localparam logic [55:0] SEGS_ZERO = {8{7'h01}};
   localparam logic [55:0] SEGS_1234ABCD =
      {7'h4F, 7'h12, 7'h06, 7'h4C, 7'h08, 7'h60, 7'h31, 7'h42};
   localparam logic [55:0] SEGS_FFFF0000 =
      {7'h38, 7'h38, 7'h38, 7'h38, 7'h01, 7'h01, 7'h01, 7'h01};
   localparam logic [55:0] SEGS_NEG1 =
      {7'h7E, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h4F};

   task automatic push_exp(input int f, input logic [55:0] s,
                           input logic [7:0] dpn, input logic [7:0] lit);
      exp_frame_t e;
      e.frame = f;
      e.segs  = s;
      e.dp_n  = dpn;
      e.lit   = lit;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   int         cyc     = 0;
   int         phase   = -1;
   int         last_fd = -1;
   int         fc      = 0;
   logic [7:0] cap_an  [8];
   logic [6:0] cap_a2g [8];
   logic       cap_dp  [8];

   task automatic compare_frame();
      exp_frame_t e;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      while (exp_q.size() > 0 && exp_q[0].frame < fc) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missed_frame expected frame %0d at frame %0d", e.frame, fc);
      end
      if (exp_q.size() > 0 && exp_q[0].frame == fc) begin
         e = exp_q.pop_front();
         for (int i = 0; i < 8; i++) begin
            exp_an = 8'hFF;
            if (e.lit[i]) exp_an[i] = 1'b0;
            exp_seg = e.segs[i*7 +: 7];
            chk($sformatf("f%0d_d%0d_an", fc, i), 32'(cap_an[i]), 32'(exp_an));
            chk($sformatf("f%0d_d%0d_a2g", fc, i), 32'(cap_a2g[i]), 32'(exp_seg));
            chk($sformatf("f%0d_d%0d_dp", fc, i), 32'(cap_dp[i]), 32'(e.dp_n[i]));
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         phase   = -1;
         last_fd = -1;
      end else begin
         cyc++;
         chk("an_multi_hot", 32'($countones(~an) > 1), 32'd0);
         if (frame_done) begin
            if (last_fd >= 0) chk("frame_period", 32'(cyc - last_fd), 32'd64);
            last_fd = cyc;
            fc++;
            phase = 0;
         end else if (phase >= 0) begin
            phase++;
         end
         if (phase > 0 && phase <= 60) begin
            if (phase % 8 == 1) chk($sformatf("blank_d%0d", phase / 8), 32'(an), 32'hFF);
            if (phase % 8 == 4) begin
               cap_an[phase / 8]  = an;
               cap_a2g[phase / 8] = a2g;
               cap_dp[phase / 8]  = dp;
            end
            if (phase == 60) compare_frame();
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_frame(input int n);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         #1;
         if (fc >= n) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_frame timeout waiting for frame %0d (at %0d)", n, fc);
   endtask

   task automatic do_load(input logic [31:0] d, input logic s, input logic [7:0] p);
      bus_if.digit_in = d;
      bus_if.sign_in  = s;
      bus_if.dp_in    = p;
      bus_if.load     = 1'b1;
      @(negedge clk);
      bus_if.load     = 1'b0;
   endtask

   initial begin
      rst_n           = 1'b0;
      bus_if.digit_in = '0;
      bus_if.sign_in  = 1'b0;
      bus_if.dp_in    = '0;
      bus_if.load     = 1'b0;

      // Reset state
      repeat (5) @(negedge clk);
      chk("rst_an", 32'(an), 32'hFF);
      chk("rst_a2g", 32'(a2g), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_fd", 32'(frame_done), 32'd0);

      push_exp(1, SEGS_ZERO, 8'hFF, LIT_ZERO);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rel_an0", 32'(an), 32'hFF);
      @(negedge clk);
      chk("rel_an1", 32'(an), 32'hFF);
      @(negedge clk);
      chk("rel_an2", 32'(an), 32'hFE);
      chk("rel_a2g", 32'(a2g), 32'h01);
      chk("rel_dp", 32'(dp), 32'd1);

      // Mid-frame load stays hidden until the next frame
      push_exp(2, SEGS_1234ABCD, 8'hFF, 8'hFF);
      wait_frame(1);
      repeat (20) @(negedge clk);
      do_load(32'h1234ABCD, 1'b0, 8'h00);

      // Load on the boundary cycle overrides an earlier pending load
      push_exp(3, SEGS_FFFF0000, 8'hFF, 8'hFF);
      push_exp(4, SEGS_FFFF0000, 8'hFF, 8'hFF);
      wait_frame(2);
      repeat (10) @(negedge clk);
      do_load(32'h55555555, 1'b0, 8'h00);
      repeat (52) @(negedge clk);
      do_load(32'hFFFF0000, 1'b0, 8'h00);

      // Sign and decimal points
      push_exp(5, SEGS_NEG1, 8'hFA, LIT_SIGN);
      wait_frame(4);
      repeat (10) @(negedge clk);
      do_load(32'h00000001, 1'b1, 8'h05);

      // Reset mid-frame discards the pending load and clears the display
      wait_frame(6);
      repeat (10) @(negedge clk);
      do_load(32'h87654321, 1'b0, 8'hFF);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_rst_an", 32'(an), 32'hFF);
      chk("mid_rst_a2g", 32'(a2g), 32'h7F);
      chk("mid_rst_dp", 32'(dp), 32'd1);
      chk("mid_rst_fd", 32'(frame_done), 32'd0);
      push_exp(7, SEGS_ZERO, 8'hFF, LIT_ZERO);
      push_exp(8, SEGS_ZERO, 8'hFF, LIT_ZERO);
      @(posedge clk);
      #2 rst_n = 1'b1;

      wait_frame(9);
      repeat (5) @(negedge clk);
      while (exp_q.size() > 0) begin
         exp_frame_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL unchecked_frame frame %0d never compared (last frame %0d)", e.frame, fc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_seg7_scan_driver
